// File: rtl/tinyalu_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tinyalu_param_pkg
// Description : Shared op/state encodings and parameter limits for tinyalu_param.
// Revision    : 1.0 - initial release
// ============================================================================
package tinyalu_param_pkg;

   localparam int C_W_MIN   = 2;
   localparam int C_W_MAX   = 32;
   localparam int C_LAT_MIN = 1;
   localparam int C_LAT_MAX = 8;

   typedef enum logic [2:0] {
      OP_NOP = 3'b000,
      OP_ADD = 3'b001,
      OP_AND = 3'b010,
      OP_XOR = 3'b011,
      OP_MUL = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SINGLE = 2'd1,
      MULT   = 2'd2
   } state_e;

   function automatic logic is_illegal_op(input logic [2:0] op);
      return (op > OP_MUL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tinyalu_param_mul.sv
`default_nettype none
// ============================================================================
// Module      : tinyalu_param_mul
// Description : Pipelined unsigned multiplier; full 2W-bit product is visible
//               on 'product' MUL_LAT cycles after the load edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tinyalu_param_mul #(
   parameter int W       = 8,
   parameter int MUL_LAT = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] product
);

   logic [2*W-1:0] r_pipe [MUL_LAT];
   logic [2*W-1:0] w_a_ext;
   logic [2*W-1:0] w_b_ext;

   assign w_a_ext = {{W{1'b0}}, a};
   assign w_b_ext = {{W{1'b0}}, b};

   // Stage 0 captures on load only; later stages just delay it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
      end else begin
         if (load) r_pipe[0] <= w_a_ext * w_b_ext;
         for (int i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign product = r_pipe[MUL_LAT-1];

endmodule
`default_nettype wire

// File: rtl/tinyalu_param.sv
`default_nettype none
// ============================================================================
// Module      : tinyalu_param
// Description : Small multi-cycle ALU (add/and/xor 1 cycle, mul MUL_LAT cycles).
//               Define TINYALU_PARAM_ERR_EN to add the 'err' illegal-op port.
// Revision    : 1.0 - initial release
// ============================================================================
module tinyalu_param
   import tinyalu_param_pkg::*;
#(
   parameter int W       = 8,
   parameter int MUL_LAT = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [2:0]     op,
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   output logic           done,
   output logic           busy,
   output logic [2*W-1:0] result
`ifdef TINYALU_PARAM_ERR_EN
   ,
   output logic           err
`endif
);

   localparam int C_CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(MUL_LAT - 1);
   localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

   if (W < C_W_MIN || W > C_W_MAX) begin : g_bad_w
      $fatal(1, "tinyalu_param: W=%0d outside legal range 2..32", W);
   end
   if (MUL_LAT < C_LAT_MIN || MUL_LAT > C_LAT_MAX) begin : g_bad_lat
      $fatal(1, "tinyalu_param: MUL_LAT=%0d outside legal range 1..8", MUL_LAT);
   end

   state_e               r_state;
   state_e               w_state_nxt;
   logic [2:0]           r_op;
   logic [W-1:0]         r_a;
   logic [W-1:0]         r_b;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [2*W-1:0]       r_result;
   logic [2*W-1:0]       w_new;
   logic [2*W-1:0]       w_product;
   logic [W:0]           w_sum;
   logic                 w_accept;
   logic                 w_mul_load;

   assign w_accept   = (r_state == IDLE) && start;
   assign w_mul_load = w_accept && (op == OP_MUL);

   tinyalu_param_mul #(
      .W       (W),
      .MUL_LAT (MUL_LAT)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .load    (w_mul_load),
      .a       (A),
      .b       (B),
      .product (w_product)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_op     <= OP_NOP;
         r_a      <= '0;
         r_b      <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op <= op;
            r_a  <= A;
            r_b  <= B;
         end
         if (w_mul_load) begin
            r_cnt <= C_CNT_INIT;
         end else if (r_state == MULT && r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_ONE;
         end
         if (done) r_result <= w_new;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_ADD, OP_AND, OP_XOR: w_state_nxt = SINGLE;
                  OP_MUL:                 w_state_nxt = MULT;
                  default: begin
`ifdef TINYALU_PARAM_ERR_EN
                     if (is_illegal_op(op)) w_state_nxt = SINGLE;
`endif
                  end
               endcase
            end
         end
         SINGLE:  w_state_nxt = IDLE;
         MULT:    if (r_cnt == '0) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_sum = {1'b0, r_a} + {1'b0, r_b};

   // Illegal ops fall through to the held result so it stays unchanged.
   always_comb begin
      w_new = r_result;
      case (r_op)
         OP_ADD:  w_new = {{(W-1){1'b0}}, w_sum};
         OP_AND:  w_new = {{W{1'b0}}, r_a & r_b};
         OP_XOR:  w_new = {{W{1'b0}}, r_a ^ r_b};
         OP_MUL:  w_new = w_product;
         default: w_new = r_result;
      endcase
   end

   assign busy   = (r_state != IDLE);
   assign done   = (r_state == SINGLE) || (r_state == MULT && r_cnt == '0);
   assign result = done ? w_new : r_result;

`ifdef TINYALU_PARAM_ERR_EN
   assign err = (r_state == SINGLE) && is_illegal_op(r_op);
`endif

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_tinyalu_param
// Description : Directed, table-driven bench for tinyalu_param (W=8/LAT=3 and W=16/LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tinyalu_param;
   import tinyalu_param_pkg::*;

`ifdef TINYALU_PARAM_ERR_EN
   localparam int ILL_LAT = 1;
`else
   localparam int ILL_LAT = 0;
`endif

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] res;
      int          lat;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        done;
   logic        busy;
   logic [15:0] result;

   logic        start16 = 1'b0;
   logic [2:0]  op16 = 3'b000;
   logic [15:0] a16 = '0;
   logic [15:0] b16 = '0;
   logic        done16;
   logic        busy16;
   logic [31:0] result16;

`ifdef TINYALU_PARAM_ERR_EN
   logic        err;
   logic        err16;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tinyalu_param #(.W(8), .MUL_LAT(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .A      (a),
      .B      (b),
      .done   (done),
      .busy   (busy),
      .result (result)
`ifdef TINYALU_PARAM_ERR_EN
      ,
      .err    (err)
`endif
   );

   tinyalu_param #(.W(16), .MUL_LAT(1)) dut16 (
      .clk    (clk),
      .reset  (reset),
      .start  (start16),
      .op     (op16),
      .A      (a16),
      .B      (b16),
      .done   (done16),
      .busy   (busy16),
      .result (result16)
`ifdef TINYALU_PARAM_ERR_EN
      ,
      .err    (err16)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Accept one op, then watch 8 cycles; start is re-pulsed with a different
   // op through the done cycle and operands are scrambled to prove isolation.
   task automatic run_op(input vec_t v, input string name);
      int          lat = 0;
      int          ndone = 0;
      int          nbusy = 0;
      int          consec = 0;
      int          nerr = 0;
      int          err_alone = 0;
      logic        prev_done = 1'b0;
      logic [15:0] res_at_done = '0;
      @(negedge clk);
      start = 1'b1; op = v.op; a = v.a; b = v.b;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         start = (c <= v.lat); op = OP_ADD; a = ~v.a; b = ~v.b;
         if (done) begin
            ndone++;
            if (lat == 0) lat = c;
            res_at_done = result;
            if (prev_done) consec++;
         end
         prev_done = done;
         if (busy) nbusy++;
`ifdef TINYALU_PARAM_ERR_EN
         if (err) begin
            nerr++;
            if (!done) err_alone++;
         end
`endif
      end
      start = 1'b0;
      check({name, " latency"}, lat, v.lat);
      check({name, " done count"}, ndone, (v.lat > 0) ? 1 : 0);
      check({name, " busy cycles"}, nbusy, v.lat);
      check({name, " consecutive done"}, consec, 0);
      check({name, " held result"}, {16'h0, result}, {16'h0, v.res});
      if (v.lat > 0) check({name, " result at done"}, {16'h0, res_at_done}, {16'h0, v.res});
`ifdef TINYALU_PARAM_ERR_EN
      check({name, " err count"}, nerr, is_illegal_op(v.op) ? 1 : 0);
      check({name, " err without done"}, err_alone, 0);
`endif
   endtask

   vec_t vecs[11];

   initial begin
      int ndone_rst;
      vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 16'h0100, 1};
      vecs[1]  = '{OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 3};
      vecs[2]  = '{OP_XOR, 8'hA5, 8'h0F, 16'h00AA, 1};
      vecs[3]  = '{OP_NOP, 8'h5A, 8'h5A, 16'h00AA, 0};
      vecs[4]  = '{OP_AND, 8'hF0, 8'h3C, 16'h0030, 1};
      vecs[5]  = '{OP_XOR, 8'hFF, 8'hFF, 16'h0000, 1};
      vecs[6]  = '{OP_ADD, 8'h80, 8'h80, 16'h0100, 1};
      vecs[7]  = '{OP_MUL, 8'h00, 8'h37, 16'h0000, 3};
      vecs[8]  = '{OP_MUL, 8'h0C, 8'h0D, 16'h009C, 3};
      vecs[9]  = '{3'b110, 8'h12, 8'h34, 16'h009C, ILL_LAT};
      vecs[10] = '{3'b101, 8'h77, 8'h88, 16'h009C, ILL_LAT};

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset done", {31'h0, done}, 32'h0);
      check("reset busy", {31'h0, busy}, 32'h0);
      check("reset result", {16'h0, result}, 32'h0);
      check("reset result16", result16, 32'h0);
`ifdef TINYALU_PARAM_ERR_EN
      check("reset err", {31'h0, err}, 32'h0);
`endif
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset during the 2nd cycle of a multiply aborts it
      @(negedge clk);
      start = 1'b1; op = OP_MUL; a = 8'h12; b = 8'h34;
      @(negedge clk);
      start = 1'b0;
      check("abort busy c1", {31'h0, busy}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort busy", {31'h0, busy}, 32'h0);
      check("abort result", {16'h0, result}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      ndone_rst = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done) ndone_rst++;
      end
      check("abort no done", ndone_rst, 0);
      check("abort result held", {16'h0, result}, 32'h0);
      run_op('{OP_AND, 8'hF0, 8'h3C, 16'h0030, 1}, "and after abort");

      // W=16, MUL_LAT=1 multiply
      @(negedge clk);
      start16 = 1'b1; op16 = OP_MUL; a16 = 16'hFFFF; b16 = 16'h0002;
      @(negedge clk);
      start16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
      check("w16 done c1", {31'h0, done16}, 32'h1);
      check("w16 busy c1", {31'h0, busy16}, 32'h1);
      check("w16 result c1", result16, 32'h0001FFFE);
      @(negedge clk);
      check("w16 done c2", {31'h0, done16}, 32'h0);
      check("w16 busy c2", {31'h0, busy16}, 32'h0);
      check("w16 result held", result16, 32'h0001FFFE);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tinyalu_param.md
TINYALU_PARAM -- requirements
Module: tinyalu_param

Interface
REQ-001 Parameter W, default 8, operand width in bits (legal range 2..32).
REQ-002 Parameter MUL_LAT, default 3, multiply latency in cycles (legal range 1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request strobe, sampled only in IDLE.
REQ-006 op  input  3  operation: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101-111 illegal.
REQ-007 A  input  W  operand A, unsigned.
REQ-008 B  input  W  operand B, unsigned.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 busy  output  1  high while an accepted operation is in progress.
REQ-011 result  output  2W  operation result, held between done pulses.
REQ-012 err  output  1  illegal-op pulse; present only when TINYALU_PARAM_ERR_EN is defined.

Function
REQ-013 FSM states SHALL be IDLE, SINGLE and MULT; reset state is IDLE.
REQ-014 Accept: in IDLE with start=1, op, A and B SHALL be registered at that edge; later input changes have no effect on that operation.
REQ-015 IDLE + start + op in {add, and, xor} -> SINGLE; SINGLE -> IDLE after one cycle, with done=1 during the SINGLE cycle (latency 1).
REQ-016 IDLE + start + op=mul -> MULT; an internal counter loads MUL_LAT-1 and decrements each cycle; done=1 in the cycle the counter equals 0, then -> IDLE (latency MUL_LAT).
REQ-017 IDLE + start + op=no_op SHALL stay in IDLE with no done pulse, and result unchanged.
REQ-018 add: result = zero-extended A+B, carry in bit W, upper bits zero.
REQ-019 and: result = zero-extended A&B; xor: result = zero-extended A^B (true XOR, not OR).
REQ-020 mul: result = full 2W-bit unsigned product A*B, no truncation.
REQ-021 result SHALL update in the same cycle done is asserted and hold until the next done.
REQ-022 busy SHALL be 1 in SINGLE and MULT and 0 in IDLE.
REQ-023 start while busy=1 SHALL be ignored: no queuing and no effect on the operation in progress.
REQ-024 Back-to-back: start asserted in the cycle done=1 is ignored; the next accept is possible in the following IDLE cycle.
REQ-025 done SHALL never be asserted in consecutive cycles.

Reset
REQ-026 On reset: state=IDLE, done=0, busy=0, result=0, err=0, and the multiply counter cleared.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first accept is possible on the first rising edge after reset deasserts.

Configuration
REQ-028 With TINYALU_PARAM_ERR_EN defined: an accepted illegal op goes IDLE -> SINGLE, pulses done=1 and err=1 together, and leaves result unchanged.
REQ-029 Without TINYALU_PARAM_ERR_EN: the err port is absent and illegal ops behave exactly as no_op (REQ-017).

Structure
REQ-030 A shared package tinyalu_param_pkg SHALL hold the op enum (3-bit encoding per REQ-006) and the FSM state enum.
REQ-031 Multiply SHALL be a sub-module tinyalu_param_mul, parametrised by W and MUL_LAT, with a registered 2W-bit product valid MUL_LAT cycles after load.
REQ-032 Parameter legality (REQ-001, REQ-002) SHALL be checked at elaboration, with a fatal error on violation.

Verification (W=8, MUL_LAT=3 unless stated)
REQ-033 add A=8'hFF, B=8'h01 -> done one cycle after accept, result=16'h0100, busy high for 1 cycle.
REQ-034 mul A=8'hFF, B=8'hFF -> done exactly 3 cycles after accept, result=16'hFE01; start pulses during busy are ignored.
REQ-035 xor A=8'hA5, B=8'h0F -> result=16'h00AA; then no_op -> no done pulse and result still 16'h00AA.
REQ-036 reset asserted in the 2nd cycle of a mul -> no done pulse, result=0; a following and A=8'hF0, B=8'h3C -> result=16'h0030.
REQ-037 op=3'b110 with the macro defined -> done=1 and err=1 in the same cycle, result unchanged; with the macro undefined -> no done pulse.
REQ-038 W=16, MUL_LAT=1: mul A=16'hFFFF, B=16'h0002 -> done 1 cycle after accept, result=32'h0001FFFE.
